// File: rtl/reg_file_mp_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_mp_if
//  Purpose  : Read, write and allocation bus bundle for the multi-port
//             integer register file. Read ports, write-back ports and issue
//             allocation ports are packed flat, with port i in slice i.
//  Revision : 1.0  initial release
// ============================================================================
interface reg_file_mp_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_READ      = 4,
  parameter int NUM_WRITE     = 2
) ();

  // Read side (decode / issue)
  logic [NUM_READ*ADDRESS_WIDTH-1:0]  rd_addr;
  logic [NUM_READ*DATA_WIDTH-1:0]     rd_data;
  logic [NUM_READ-1:0]                rd_busy;

  // Write-back side (one port per lane)
  logic [NUM_WRITE-1:0]               wr_en;
  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] wr_addr;
  logic [NUM_WRITE*DATA_WIDTH-1:0]    wr_data;

  // Issue-time destination allocation (one port per lane)
  logic [NUM_WRITE-1:0]               alloc_en;
  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] alloc_addr;

  // Pipeline side: drives addresses / data, receives read results
  modport master (
    output rd_addr,
    input  rd_data,
    input  rd_busy,
    output wr_en,
    output wr_addr,
    output wr_data,
    output alloc_en,
    output alloc_addr
  );

  // Register file side
  modport slave (
    input  rd_addr,
    output rd_data,
    output rd_busy,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  alloc_en,
    input  alloc_addr
  );

endinterface
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_mp
//  Purpose  : Multi-port integer register file with combinational reads,
//             posedge writes, write-to-read bypass, a busy scoreboard driven
//             by issue/writeback and sticky write-port conflict detection.
//  Revision : 1.0  initial release
// ============================================================================
module reg_file_mp #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_READ      = 4,
  parameter int NUM_WRITE     = 2,
  parameter int BYPASS        = 1
) (
  input  wire logic                         clk,
  input  wire logic                         rst_n,
  reg_file_mp_if.slave                      bus,
  output logic [(2**ADDRESS_WIDTH)-1:0]     busy_vec,
  output logic                              wr_conflict,
  input  wire logic                         clr_conflict,
  output logic [DATA_WIDTH-1:0]             a0,
  output logic [DATA_WIDTH-1:0]             a1
);

  localparam int DEPTH = 2**ADDRESS_WIDTH;

  // Architectural state
  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH-1:0]         busy_q;
  logic                     conflict_q;

  // Unpacked views of the flat bus slices
  logic [ADDRESS_WIDTH-1:0] wa [NUM_WRITE];
  logic [DATA_WIDTH-1:0]    wd [NUM_WRITE];
  logic [ADDRESS_WIDTH-1:0] aa [NUM_WRITE];
  logic [ADDRESS_WIDTH-1:0] ra [NUM_READ];

  // Per-cycle derived terms
  logic                     new_conflict;
  logic [DEPTH-1:0]         set_vec;
  logic [DEPTH-1:0]         clr_vec;
  logic                     hit   [NUM_READ];
  logic [DATA_WIDTH-1:0]    fwd   [NUM_READ];

  generate
    for (genvar j = 0; j < NUM_WRITE; j++) begin : g_wr_unpack
      assign wa[j] = bus.wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      assign wd[j] = bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
      assign aa[j] = bus.alloc_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    end
    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd_unpack
      assign ra[i] = bus.rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    end
  endgenerate

  // Any pair of enabled write ports aiming at the same nonzero register
  always_comb begin
    new_conflict = 1'b0;
    for (int j = 0; j < NUM_WRITE; j++) begin
      for (int k = j + 1; k < NUM_WRITE; k++) begin
        if (bus.wr_en[j] && bus.wr_en[k] && (wa[j] == wa[k]) &&
            (wa[j] != '0)) begin
          new_conflict = 1'b1;
        end
      end
    end
  end

  // Decode allocation (set) and writeback (clear) requests per register;
  // x0 can never become busy
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (bus.alloc_en[j]) set_vec[aa[j]] = 1'b1;
      if (bus.wr_en[j])    clr_vec[wa[j]] = 1'b1;
    end
    set_vec[0] = 1'b0;
  end

  // Register array: later ports overwrite earlier ones, so the highest
  // indexed enabled port wins a same-address collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (bus.wr_en[j] && (wa[j] != '0)) begin
          mem[wa[j]] <= wd[j];
        end
      end
    end
  end

  // Scoreboard: a new allocation outranks a writeback from an older producer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= set_vec | (busy_q & ~clr_vec);
    end
  end

  // Sticky conflict flag; a fresh conflict beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= 1'b0;
    end else if (new_conflict) begin
      conflict_q <= 1'b1;
    end else if (clr_conflict) begin
      conflict_q <= 1'b0;
    end
  end

  // Read ports: forward the highest-indexed matching write when bypass is
  // enabled, otherwise return the array; x0 always reads as 0 and not busy
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      hit[i] = 1'b0;
      fwd[i] = '0;
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (bus.wr_en[j] && (wa[j] == ra[i])) begin
          hit[i] = 1'b1;
          fwd[i] = wd[j];
        end
      end
      if (ra[i] != '0) begin
        if ((BYPASS != 0) && hit[i]) begin
          bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = fwd[i];
        end else begin
          bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[ra[i]];
        end
        bus.rd_busy[i] = busy_q[ra[i]] & ~((BYPASS != 0) && hit[i]);
      end
    end
  end

  assign busy_vec    = busy_q;
  assign wr_conflict = conflict_q;
  assign a0          = mem[10];
  assign a1          = mem[11];

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_mp
//  Purpose  : Self-checking bench for reg_file_mp. Two instances (bypass on
//             and off) share one stimulus stream and are compared against a
//             behavioural register-file model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_file_mp;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NR    = 4;
  localparam int NW    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_conflict = 1'b0;

  logic [DEPTH-1:0] busy_vec1, busy_vec0;
  logic             wr_conflict1, wr_conflict0;
  logic [DW-1:0]    a0_1, a1_1, a0_0, a1_0;

  reg_file_mp_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .NUM_WRITE(NW)) bus1 ();
  reg_file_mp_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .NUM_WRITE(NW)) bus0 ();

  assign bus0.rd_addr    = bus1.rd_addr;
  assign bus0.wr_en      = bus1.wr_en;
  assign bus0.wr_addr    = bus1.wr_addr;
  assign bus0.wr_data    = bus1.wr_data;
  assign bus0.alloc_en   = bus1.alloc_en;
  assign bus0.alloc_addr = bus1.alloc_addr;

  reg_file_mp #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .NUM_WRITE(NW), .BYPASS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .busy_vec(busy_vec1), .wr_conflict(wr_conflict1),
    .clr_conflict(clr_conflict), .a0(a0_1), .a1(a1_1));

  reg_file_mp #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .NUM_WRITE(NW), .BYPASS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .busy_vec(busy_vec0), .wr_conflict(wr_conflict0),
    .clr_conflict(clr_conflict), .a0(a0_0), .a1(a1_0));

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0]    m_reg [DEPTH];
  logic [DEPTH-1:0] m_busy;
  logic             m_conf;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- model -------------------------------------------------
  task automatic model_reset();
    for (int r = 0; r < DEPTH; r++) m_reg[r] = '0;
    m_busy = '0;
    m_conf = 1'b0;
  endtask

  function automatic logic [DW-1:0] exp_data(input int port, input bit byp);
    logic [AW-1:0] a;
    a = bus1.rd_addr[port*AW +: AW];
    if (a == 0) return '0;
    if (byp) begin
      for (int j = NW - 1; j >= 0; j--) begin
        if (bus1.wr_en[j] && bus1.wr_addr[j*AW +: AW] == a) return bus1.wr_data[j*DW +: DW];
      end
    end
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input int port, input bit byp);
    logic [AW-1:0] a;
    bit written;
    a = bus1.rd_addr[port*AW +: AW];
    written = 0;
    if (a == 0) return 1'b0;
    for (int j = 0; j < NW; j++) begin
      if (bus1.wr_en[j] && bus1.wr_addr[j*AW +: AW] == a) written = 1;
    end
    return m_busy[a] && !(byp && written);
  endfunction

  // Apply the current inputs to the model, then advance one clock
  task automatic step();
    bit newc;
    bit s, c;
    logic [DEPTH-1:0] nb;
    if (rst_n) begin
      newc = 0;
      for (int j = 0; j < NW; j++)
        for (int k = 0; k < NW; k++)
          if (j != k && bus1.wr_en[j] && bus1.wr_en[k] &&
              bus1.wr_addr[j*AW +: AW] == bus1.wr_addr[k*AW +: AW] &&
              bus1.wr_addr[j*AW +: AW] != 0) newc = 1;
      if (newc) m_conf = 1'b1;
      else if (clr_conflict) m_conf = 1'b0;
      nb = '0;
      for (int r = 1; r < DEPTH; r++) begin
        s = 0; c = 0;
        for (int j = 0; j < NW; j++) begin
          if (bus1.alloc_en[j] && bus1.alloc_addr[j*AW +: AW] == r) s = 1;
          if (bus1.wr_en[j] && bus1.wr_addr[j*AW +: AW] == r) c = 1;
        end
        nb[r] = s | (m_busy[r] & ~c);
      end
      m_busy = nb;
      for (int j = 0; j < NW; j++)
        if (bus1.wr_en[j] && bus1.wr_addr[j*AW +: AW] != 0)
          m_reg[bus1.wr_addr[j*AW +: AW]] = bus1.wr_data[j*DW +: DW];
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus helpers --------------------------------------
  task automatic clear_inputs();
    bus1.rd_addr = '0; bus1.wr_en = '0; bus1.wr_addr = '0; bus1.wr_data = '0;
    bus1.alloc_en = '0; bus1.alloc_addr = '0; clr_conflict = 1'b0;
  endtask

  task automatic drive_wr(input int j, input bit en, input int addr, input logic [DW-1:0] data);
    bus1.wr_en[j] = en;
    bus1.wr_addr[j*AW +: AW] = addr[AW-1:0];
    bus1.wr_data[j*DW +: DW] = data;
  endtask

  task automatic drive_alloc(input int j, input bit en, input int addr);
    bus1.alloc_en[j] = en;
    bus1.alloc_addr[j*AW +: AW] = addr[AW-1:0];
  endtask

  task automatic drive_rd(input int i, input int addr);
    bus1.rd_addr[i*AW +: AW] = addr[AW-1:0];
  endtask

  function automatic int rand_addr();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 31));
    return int'($urandom_range(0, 11));
  endfunction

  // ---------------- tests -------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    #2;
    for (int g = 0; g < DEPTH / NR; g++) begin
      for (int i = 0; i < NR; i++) drive_rd(i, g * NR + i);
      #1;
      for (int i = 0; i < NR; i++) begin
        n_checks++;
        if (bus1.rd_data[i*DW +: DW] !== '0 || bus0.rd_data[i*DW +: DW] !== '0) begin
          n_fail++;
          $display("FAIL reset_rd addr=%0d: got %h/%h expected 0", g * NR + i,
                   bus1.rd_data[i*DW +: DW], bus0.rd_data[i*DW +: DW]);
        end
      end
    end
    n_checks++;
    if (busy_vec1 !== '0 || busy_vec0 !== '0) begin
      n_fail++; $display("FAIL reset_busy: got %h/%h expected 0", busy_vec1, busy_vec0);
    end
    n_checks++;
    if (wr_conflict1 !== 1'b0 || wr_conflict0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_conflict: got %b/%b expected 0", wr_conflict1, wr_conflict0);
    end
    n_checks++;
    if (a0_1 !== '0 || a1_1 !== '0 || a0_0 !== '0 || a1_0 !== '0) begin
      n_fail++; $display("FAIL reset_a0a1: got %h %h %h %h expected 0", a0_1, a1_1, a0_0, a1_0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    step();
  endtask

  task automatic test_bypass();
    clear_inputs();
    drive_wr(0, 1, 10, 32'hDEADBEEF);
    drive_rd(3, 10);
    #1;
    n_checks++;
    if (bus1.rd_data[3*DW +: DW] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass_on_same_cycle: got %h expected deadbeef", bus1.rd_data[3*DW +: DW]);
    end
    n_checks++;
    if (bus0.rd_data[3*DW +: DW] !== 32'h0) begin
      n_fail++; $display("FAIL bypass_off_same_cycle: got %h expected 0", bus0.rd_data[3*DW +: DW]);
    end
    step();
    drive_wr(0, 0, 0, 0);
    #1;
    n_checks++;
    if (a0_1 !== 32'hDEADBEEF || a0_0 !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass_a0_after: got %h/%h expected deadbeef", a0_1, a0_0);
    end
    n_checks++;
    if (bus1.rd_data[3*DW +: DW] !== 32'hDEADBEEF || bus0.rd_data[3*DW +: DW] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass_rd_after: got %h/%h expected deadbeef",
                         bus1.rd_data[3*DW +: DW], bus0.rd_data[3*DW +: DW]);
    end
  endtask

  task automatic test_x0();
    clear_inputs();
    drive_wr(0, 1, 0, 32'h1234);
    drive_wr(1, 1, 0, 32'h1234);
    drive_alloc(0, 1, 0);
    #1;
    for (int i = 0; i < NR; i++) begin
      n_checks++;
      if (bus1.rd_data[i*DW +: DW] !== '0 || bus0.rd_data[i*DW +: DW] !== '0 ||
          bus1.rd_busy[i] !== 1'b0) begin
        n_fail++; $display("FAIL x0_read port=%0d: got %h/%h busy=%b expected 0", i,
                           bus1.rd_data[i*DW +: DW], bus0.rd_data[i*DW +: DW], bus1.rd_busy[i]);
      end
    end
    step();
    clear_inputs();
    #1;
    n_checks++;
    if (busy_vec1 !== '0 || busy_vec0 !== '0) begin
      n_fail++; $display("FAIL x0_busy: got %h/%h expected 0", busy_vec1, busy_vec0);
    end
    n_checks++;
    if (wr_conflict1 !== 1'b0 || wr_conflict0 !== 1'b0) begin
      n_fail++; $display("FAIL x0_conflict: got %b/%b expected 0", wr_conflict1, wr_conflict0);
    end
  endtask

  task automatic test_conflict();
    clear_inputs();
    drive_wr(0, 1, 5, 32'h11);
    drive_wr(1, 1, 5, 32'h22);
    drive_rd(0, 5);
    #1;
    n_checks++;
    if (bus1.rd_data[DW-1:0] !== 32'h22) begin
      n_fail++; $display("FAIL conflict_bypass_priority: got %h expected 22", bus1.rd_data[DW-1:0]);
    end
    n_checks++;
    if (wr_conflict1 !== 1'b0) begin
      n_fail++; $display("FAIL conflict_not_yet: got %b expected 0", wr_conflict1);
    end
    step();
    drive_wr(0, 0, 0, 0);
    drive_wr(1, 0, 0, 0);
    #1;
    n_checks++;
    if (wr_conflict1 !== 1'b1 || wr_conflict0 !== 1'b1) begin
      n_fail++; $display("FAIL conflict_set: got %b/%b expected 1", wr_conflict1, wr_conflict0);
    end
    n_checks++;
    if (bus1.rd_data[DW-1:0] !== 32'h22 || bus0.rd_data[DW-1:0] !== 32'h22) begin
      n_fail++; $display("FAIL conflict_winner: got %h/%h expected 22", bus1.rd_data[DW-1:0], bus0.rd_data[DW-1:0]);
    end
    step();
    n_checks++;
    if (wr_conflict1 !== 1'b1) begin
      n_fail++; $display("FAIL conflict_sticky: got %b expected 1", wr_conflict1);
    end
    clr_conflict = 1'b1;
    step();
    clr_conflict = 1'b0;
    n_checks++;
    if (wr_conflict1 !== 1'b0 || wr_conflict0 !== 1'b0) begin
      n_fail++; $display("FAIL conflict_clear: got %b/%b expected 0", wr_conflict1, wr_conflict0);
    end
    drive_wr(0, 1, 6, 32'h33);
    drive_wr(1, 1, 6, 32'h44);
    clr_conflict = 1'b1;
    step();
    clear_inputs();
    n_checks++;
    if (wr_conflict1 !== 1'b1) begin
      n_fail++; $display("FAIL conflict_set_beats_clear: got %b expected 1", wr_conflict1);
    end
    clr_conflict = 1'b1;
    step();
    clr_conflict = 1'b0;
  endtask

  task automatic test_busy();
    clear_inputs();
    drive_alloc(0, 1, 7);
    step();
    drive_alloc(0, 0, 0);
    drive_rd(0, 7);
    #1;
    n_checks++;
    if (bus1.rd_busy[0] !== 1'b1 || busy_vec1[7] !== 1'b1) begin
      n_fail++; $display("FAIL busy_alloc: got rd_busy=%b vec=%b expected 1", bus1.rd_busy[0], busy_vec1[7]);
    end
    drive_wr(1, 1, 7, 32'h55);
    #1;
    n_checks++;
    if (bus1.rd_busy[0] !== 1'b0 || bus1.rd_data[DW-1:0] !== 32'h55) begin
      n_fail++; $display("FAIL busy_writeback_bypass: got busy=%b data=%h expected 0/55",
                         bus1.rd_busy[0], bus1.rd_data[DW-1:0]);
    end
    n_checks++;
    if (bus0.rd_busy[0] !== 1'b1 || bus0.rd_data[DW-1:0] !== 32'h0) begin
      n_fail++; $display("FAIL busy_writeback_nobypass: got busy=%b data=%h expected 1/0",
                         bus0.rd_busy[0], bus0.rd_data[DW-1:0]);
    end
    step();
    drive_wr(1, 0, 0, 0);
    #1;
    n_checks++;
    if (busy_vec1[7] !== 1'b0 || busy_vec0[7] !== 1'b0 || bus0.rd_data[DW-1:0] !== 32'h55) begin
      n_fail++; $display("FAIL busy_cleared: got %b/%b data=%h expected 0/0/55",
                         busy_vec1[7], busy_vec0[7], bus0.rd_data[DW-1:0]);
    end
    drive_alloc(0, 1, 7);
    drive_wr(1, 1, 7, 32'h66);
    step();
    clear_inputs();
    drive_rd(0, 7);
    #1;
    n_checks++;
    if (busy_vec1[7] !== 1'b1 || bus1.rd_data[DW-1:0] !== 32'h66) begin
      n_fail++; $display("FAIL busy_alloc_beats_wb: got busy=%b data=%h expected 1/66",
                         busy_vec1[7], bus1.rd_data[DW-1:0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      for (int j = 0; j < NW; j++) begin
        drive_wr(j, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        drive_alloc(j, ($urandom_range(0, 2) == 0), rand_addr());
      end
      for (int i = 0; i < NR; i++) drive_rd(i, rand_addr());
      clr_conflict = ($urandom_range(0, 7) == 0);
      #1;
      for (int i = 0; i < NR; i++) begin
        n_checks++;
        if (bus1.rd_data[i*DW +: DW] !== exp_data(i, 1) || bus0.rd_data[i*DW +: DW] !== exp_data(i, 0)) begin
          n_fail++; $display("FAIL rand_rd_data it=%0d port=%0d: got %h/%h expected %h/%h", n, i,
                             bus1.rd_data[i*DW +: DW], bus0.rd_data[i*DW +: DW], exp_data(i, 1), exp_data(i, 0));
        end
        n_checks++;
        if (bus1.rd_busy[i] !== exp_busy(i, 1) || bus0.rd_busy[i] !== exp_busy(i, 0)) begin
          n_fail++; $display("FAIL rand_rd_busy it=%0d port=%0d: got %b/%b expected %b/%b", n, i,
                             bus1.rd_busy[i], bus0.rd_busy[i], exp_busy(i, 1), exp_busy(i, 0));
        end
      end
      n_checks++;
      if (busy_vec1 !== m_busy || busy_vec0 !== m_busy) begin
        n_fail++; $display("FAIL rand_busy_vec it=%0d: got %h/%h expected %h", n, busy_vec1, busy_vec0, m_busy);
      end
      n_checks++;
      if (wr_conflict1 !== m_conf || wr_conflict0 !== m_conf) begin
        n_fail++; $display("FAIL rand_conflict it=%0d: got %b/%b expected %b", n, wr_conflict1, wr_conflict0, m_conf);
      end
      n_checks++;
      if (a0_1 !== m_reg[10] || a1_1 !== m_reg[11] || a0_0 !== m_reg[10] || a1_0 !== m_reg[11]) begin
        n_fail++; $display("FAIL rand_a0a1 it=%0d: got %h %h expected %h %h", n, a0_1, a1_1, m_reg[10], m_reg[11]);
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    clear_inputs();
    drive_wr(0, 1, 10, 32'hA5A5_0001);
    drive_wr(1, 1, 10, 32'hA5A5_0002);
    drive_alloc(0, 1, 3);
    step();
    clear_inputs();
    drive_rd(0, 10);
    #1;
    n_checks++;
    if (a0_1 !== 32'hA5A5_0002 || wr_conflict1 !== 1'b1 || busy_vec1[3] !== 1'b1) begin
      n_fail++; $display("FAIL arst_setup: got a0=%h conf=%b busy3=%b expected a5a50002/1/1",
                         a0_1, wr_conflict1, busy_vec1[3]);
    end
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (a0_1 !== '0 || a0_0 !== '0 || bus1.rd_data[DW-1:0] !== '0 || bus0.rd_data[DW-1:0] !== '0) begin
      n_fail++; $display("FAIL arst_data: got a0=%h/%h rd=%h/%h expected 0", a0_1, a0_0,
                         bus1.rd_data[DW-1:0], bus0.rd_data[DW-1:0]);
    end
    n_checks++;
    if (busy_vec1 !== '0 || busy_vec0 !== '0 || wr_conflict1 !== 1'b0 || wr_conflict0 !== 1'b0) begin
      n_fail++; $display("FAIL arst_state: got busy=%h/%h conf=%b/%b expected 0", busy_vec1, busy_vec0,
                         wr_conflict1, wr_conflict0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++;
    if (a0_1 !== '0 || busy_vec1 !== '0) begin
      n_fail++; $display("FAIL arst_after_release: got a0=%h busy=%h expected 0", a0_1, busy_vec1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_bypass();
    test_x0();
    test_conflict();
    test_busy();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
